// File: rtl/instr_decode_stage.sv
// MIPS decode stage: field split, immediate extension, jump/branch targets.
// Registered output with optional two-entry skid buffer and handshake counter.
module instr_decode_stage #(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [XLEN-1:0]  pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [XLEN-1:0]  imm_ext,
  output logic [XLEN-1:0]  jump_target,
  output logic [XLEN-1:0]  branch_target,
  output logic             is_r,
  output logic             is_i,
  output logic             is_j,
  output logic             is_link,
  output logic [CNT_W-1:0] dec_count
);

  typedef struct packed {
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] branch_target;
    logic            is_r;
    logic            is_i;
    logic            is_j;
    logic            is_link;
  } dec_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t          state, state_n;
  dec_t            dec, out_q, skid_q;
  logic            ld_out, ld_skid, from_skid;
  logic            hs, acc;
  logic [5:0]      op, fn;
  logic [XLEN-1:0] pc4, sext, zext;
  logic [CNT_W-1:0] cnt_q;

  assign op   = instruction[31:26];
  assign fn   = instruction[5:0];
  assign pc4  = pc + XLEN'(4);
  assign sext = {{(XLEN-16){instruction[15]}}, instruction[15:0]};
  assign zext = {{(XLEN-16){1'b0}}, instruction[15:0]};

  always_comb begin
    dec               = '0;
    dec.opcode        = op;
    dec.jump_target   = {pc4[XLEN-1:28], instruction[25:0], 2'b00};
    dec.branch_target = pc4 + (sext << 2);
    unique case (1'b1)
      (op == 6'h00): begin
        dec.is_r    = 1'b1;
        dec.rs      = instruction[25:21];
        dec.rt      = instruction[20:16];
        dec.rd      = instruction[15:11];
        dec.shamt   = instruction[10:6];
        dec.funct   = fn;
        dec.is_link = (fn == 6'h09);
      end
      (op == 6'h02 || op == 6'h03): begin
        dec.is_j    = 1'b1;
        dec.is_link = op[0];
      end
      default: begin
        dec.is_i    = 1'b1;
        dec.rs      = instruction[25:21];
        dec.rt      = instruction[20:16];
        // logical immediates are unsigned
        dec.imm_ext = (op == 6'h0C || op == 6'h0D || op == 6'h0E)
                    ? zext : sext;
      end
    endcase
  end

  assign out_valid = (state != EMPTY);
  assign in_ready  = (SKID != 0) ? (state != FULL)
                                 : (!out_valid || out_ready);
  assign hs        = out_valid && out_ready;
  assign acc       = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    ld_out    = 1'b0;
    ld_skid   = 1'b0;
    from_skid = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state_n = ONE;
            ld_out  = 1'b1;
          end
        end
        ONE: begin
          if (acc && hs) begin
            ld_out = 1'b1;
          end else if (acc) begin
            state_n = FULL;
            ld_skid = 1'b1;
          end else if (hs) begin
            state_n = EMPTY;
          end
        end
        FULL: begin
          if (hs) begin
            state_n   = ONE;
            from_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (ld_out)         out_q <= dec;
      else if (from_skid) out_q <= skid_q;
      if (ld_skid)        skid_q <= dec;
    end
  end

  // a handshake coinciding with flush is not counted
  always_ff @(posedge clk) begin
    if (rst)              cnt_q <= '0;
    else if (hs && !flush) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign opcode        = out_q.opcode;
  assign rs            = out_q.rs;
  assign rt            = out_q.rt;
  assign rd            = out_q.rd;
  assign shamt         = out_q.shamt;
  assign funct         = out_q.funct;
  assign imm_ext       = out_q.imm_ext;
  assign jump_target   = out_q.jump_target;
  assign branch_target = out_q.branch_target;
  assign is_r          = out_q.is_r;
  assign is_i          = out_q.is_i;
  assign is_j          = out_q.is_j;
  assign is_link       = out_q.is_link;
  assign dec_count     = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: default build plus XLEN=64/SKID=0/CNT_W=4.
module tb_instr_decode_stage;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, flush0, iv0, ir0, ov0, or0;
  logic [31:0] instr0, pc0, imm0, jt0, bt0;
  logic [5:0]  op0, fn0;
  logic [4:0]  rs0, rt0, rd0, sh0;
  logic        isr0, isi0, isj0, isl0;
  logic [15:0] cnt0;

  logic        rst1, flush1, iv1, ir1, ov1, or1;
  logic [31:0] instr1;
  logic [63:0] pc1, imm1, jt1, bt1;
  logic [5:0]  op1, fn1;
  logic [4:0]  rs1, rt1, rd1, sh1;
  logic        isr1, isi1, isj1, isl1;
  logic [3:0]  cnt1;

  instr_decode_stage u0 (
    .clk(clk), .rst(rst0), .flush(flush0),
    .in_valid(iv0), .in_ready(ir0),
    .instruction(instr0), .pc(pc0),
    .out_valid(ov0), .out_ready(or0),
    .opcode(op0), .rs(rs0), .rt(rt0), .rd(rd0),
    .shamt(sh0), .funct(fn0), .imm_ext(imm0),
    .jump_target(jt0), .branch_target(bt0),
    .is_r(isr0), .is_i(isi0), .is_j(isj0),
    .is_link(isl0), .dec_count(cnt0)
  );

  instr_decode_stage #(
    .XLEN(64), .SKID(0), .CNT_W(4)
  ) u1 (
    .clk(clk), .rst(rst1), .flush(flush1),
    .in_valid(iv1), .in_ready(ir1),
    .instruction(instr1), .pc(pc1),
    .out_valid(ov1), .out_ready(or1),
    .opcode(op1), .rs(rs1), .rt(rt1), .rd(rd1),
    .shamt(sh1), .funct(fn1), .imm_ext(imm1),
    .jump_target(jt1), .branch_target(bt1),
    .is_r(isr1), .is_i(isi1), .is_j(isj1),
    .is_link(isl1), .dec_count(cnt1)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic [31:0] jt;
    logic [31:0] bt;
    logic [3:0]  fl;
  } vec_t;

  vec_t vec [10];
  int   ncmp, nbad;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill0(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    or0 = 1'b0; iv0 = 1'b1; instr0 = a; pc0 = 32'h0;
    @(negedge clk);
    instr0 = b;
    @(negedge clk);
  endtask

  localparam logic [31:0] IA = 32'h0000_0820;
  localparam logic [31:0] IB = 32'h0000_1020;
  localparam logic [31:0] IC = 32'h0000_1820;

  initial begin
    logic seen;
    int   stalls;
    ncmp = 0; nbad = 0;
    rst0 = 1'b1; flush0 = 1'b0; iv0 = 1'b0; or0 = 1'b1;
    instr0 = '0; pc0 = '0;
    rst1 = 1'b1; flush1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
    instr1 = '0; pc1 = '0;

    vec[0] = '{32'h012A4020, 32'h400, 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20,
               32'h0, 32'h04A90080, 32'h00010484, 4'b1000};
    vec[1] = '{32'h2108FFFF, 32'h1000, 6'h08, 5'd8, 5'd8, 5'd0, 5'd0, 6'h00,
               32'hFFFFFFFF, 32'h0423FFFC, 32'h00001000, 4'b0100};
    vec[2] = '{32'h3508FFFF, 32'h1004, 6'h0D, 5'd8, 5'd8, 5'd0, 5'd0, 6'h00,
               32'h0000FFFF, 32'h0423FFFC, 32'h00001004, 4'b0100};
    vec[3] = '{32'h0C100004, 32'h00400010, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0,
               6'h00, 32'h0, 32'h00400010, 32'h00400024, 4'b0011};
    vec[4] = '{32'h03E0F809, 32'h2000, 6'h00, 5'd31, 5'd0, 5'd31, 5'd0, 6'h09,
               32'h0, 32'h0F83E024, 32'h00000028, 4'b1001};
    vec[5] = '{32'h1109FFFE, 32'hF0000100, 6'h04, 5'd8, 5'd9, 5'd0, 5'd0,
               6'h00, 32'hFFFFFFFE, 32'hF427FFF8, 32'hF00000FC, 4'b0100};
    vec[6] = '{32'h3A0F8000, 32'h0, 6'h0E, 5'd16, 5'd15, 5'd0, 5'd0, 6'h00,
               32'h00008000, 32'h083E0000, 32'hFFFE0004, 4'b0100};
    vec[7] = '{32'h08000000, 32'h7FFFFFFC, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0,
               6'h00, 32'h0, 32'h80000000, 32'h80000000, 4'b0010};
    vec[8] = '{32'h3C018000, 32'h100, 6'h0F, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00,
               32'hFFFF8000, 32'h00060000, 32'hFFFE0104, 4'b0100};
    vec[9] = '{32'h00021080, 32'h10, 6'h00, 5'd0, 5'd2, 5'd2, 5'd2, 6'h00,
               32'h0, 32'h00084200, 32'h00004214, 4'b1000};

    step();
    step();
    chk("rst0 hs", {ov0, ir0}, 2'b01);
    chk("rst0 cnt", cnt0, 16'd0);
    chk("rst0 data", {op0, rs0, rt0, rd0, sh0, fn0, imm0, jt0, bt0,
                      isr0, isi0, isj0, isl0}, '0);
    chk("rst1 hs", {ov1, ir1}, 2'b01);
    chk("rst1 data", {imm1, jt1, bt1, cnt1}, '0);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv0 = 1'b1; instr0 = vec[i].instr; pc0 = vec[i].pc;
      step();
      iv0 = 1'b0;
      chk($sformatf("v%0d fields", i),
          {op0, rs0, rt0, rd0, sh0, fn0},
          {vec[i].op, vec[i].rs, vec[i].rt, vec[i].rd, vec[i].sh, vec[i].fn});
      chk($sformatf("v%0d imm", i), imm0, vec[i].imm);
      chk($sformatf("v%0d jt", i), jt0, vec[i].jt);
      chk($sformatf("v%0d bt", i), bt0, vec[i].bt);
      chk($sformatf("v%0d flags", i), {ov0, isr0, isi0, isj0, isl0},
          {1'b1, vec[i].fl});
    end
    step();
    chk("table cnt", {ov0, cnt0}, {1'b0, 16'd10});

    // stall: three offered, two taken, drained in order
    @(negedge clk);
    or0 = 1'b0; iv0 = 1'b1; instr0 = IA; pc0 = 32'h0;
    step();
    chk("stall acc1", {ov0, ir0, rd0}, {1'b1, 1'b1, 5'd1});
    @(negedge clk);
    instr0 = IB;
    step();
    chk("stall full", {ov0, ir0, rd0}, {1'b1, 1'b0, 5'd1});
    @(negedge clk);
    instr0 = IC;
    step();
    chk("stall hold", {ov0, ir0, rd0}, {1'b1, 1'b0, 5'd1});
    @(negedge clk);
    iv0 = 1'b0; or0 = 1'b1;
    step();
    chk("drain 1", {ov0, ir0, rd0}, {1'b1, 1'b1, 5'd2});
    step();
    chk("drain 2", {ov0, cnt0}, {1'b0, 16'd12});

    // flush from FULL with a concurrent offer
    fill0(IA, IB);
    chk("pre-flush full", {ov0, ir0}, 2'b10);
    flush0 = 1'b1; instr0 = IC;
    step();
    chk("flush", {ov0, ir0, cnt0}, {1'b0, 1'b1, 16'd12});
    @(negedge clk);
    flush0 = 1'b0; iv0 = 1'b0; or0 = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      step();
      seen = seen | ov0;
    end
    chk("flush stale", {seen, cnt0}, {1'b0, 16'd12});

    // reset (with flush) from FULL while downstream is ready
    fill0(IA, IB);
    rst0 = 1'b1; flush0 = 1'b1; or0 = 1'b1;
    step();
    chk("rst full hs", {ov0, ir0, cnt0}, {1'b0, 1'b1, 16'd0});
    chk("rst full data", {op0, rd0, fn0, imm0, jt0, bt0,
                          isr0, isi0, isj0, isl0}, '0);
    @(negedge clk);
    rst0 = 1'b0; flush0 = 1'b0; iv0 = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      step();
      seen = seen | ov0;
    end
    chk("rst stale", {seen, cnt0}, {1'b0, 16'd0});

    // 64-bit, single register build
    @(negedge clk);
    iv1 = 1'b1; instr1 = 32'h2108FFFF; pc1 = 64'h1000;
    step();
    chk("x64 addi imm", imm1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("x64 addi tgt", {jt1, bt1}, {64'h0423FFFC, 64'h1000});
    @(negedge clk);
    instr1 = 32'h3508FFFF; pc1 = 64'h1004;
    step();
    chk("x64 ori imm", imm1, 64'h0000_0000_0000_FFFF);
    @(negedge clk);
    instr1 = 32'h08000001; pc1 = 64'h0000_0012_3000_0000;
    step();
    iv1 = 1'b0;
    chk("x64 j tgt", {isj1, jt1}, {1'b1, 64'h0000_0012_3000_0004});
    @(negedge clk);
    or1 = 1'b0;
    #1;
    chk("skid0 rdy low", {ov1, ir1}, 2'b10);
    or1 = 1'b1;
    #1;
    chk("skid0 rdy high", {ov1, ir1}, 2'b11);

    @(negedge clk);
    rst1 = 1'b1;
    step();
    chk("x64 rst cnt", {ov1, cnt1}, {1'b0, 4'd0});
    @(negedge clk);
    rst1 = 1'b0; iv1 = 1'b1; or1 = 1'b1; instr1 = 32'h012A4020;
    stalls = 0;
    repeat (17) begin
      step();
      if (!ir1) stalls++;
    end
    iv1 = 1'b0;
    step();
    chk("wrap cnt", {ov1, cnt1}, {1'b0, 4'd1});
    chk("wrap thru", stalls, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
